// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one sign-magnitude ALU datapath between two requesters,
// holding operands for a settle window and returning results through a valid/ready register.
module alu_rr_scheduler #(
    parameter int M      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [1:0]       i_req0_op,
    input  logic [M-1:0]     i_req0_argA,
    input  logic [M-1:0]     i_req0_argB,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [1:0]       i_req1_op,
    input  logic [M-1:0]     i_req1_argA,
    input  logic [M-1:0]     i_req1_argB,
    output logic [1:0]       o_dp_op,
    output logic [M-1:0]     o_dp_argA,
    output logic [M-1:0]     o_dp_argB,
    input  logic [M-1:0]     i_dp_result,
    input  logic [3:0]       i_dp_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [M-1:0]     o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_busy
);

    localparam int         SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [1:0] OP_SM2U2 = 2'b11;

    if (SETTLE < 1) begin : gBadSettle
        $error("alu_rr_scheduler: SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             lastId_q, lastId_d;
    logic             id_q, id_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [1:0]       dpOp_q, dpOp_d;
    logic [M-1:0]     dpArgA_q, dpArgA_d;
    logic [M-1:0]     dpArgB_q, dpArgB_d;
    logic             rspId_q, rspId_d;
    logic [M-1:0]     rspResult_q, rspResult_d;
    logic [3:0]       rspStatus_q, rspStatus_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    logic             anyValid;
    logic             grant;
    logic [1:0]       selOp;
    logic [M-1:0]     selArgA;
    logic [M-1:0]     selArgB;

    // On a tie the requester that did not win last time is granted.
    assign anyValid = i_req0_valid | i_req1_valid;
    assign grant    = (i_req0_valid && i_req1_valid) ? ~lastId_q : i_req1_valid;
    assign selOp    = grant ? i_req1_op   : i_req0_op;
    assign selArgA  = grant ? i_req1_argA : i_req0_argA;
    assign selArgB  = grant ? i_req1_argB : i_req0_argB;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            lastId_q    <= 1'b1;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            dpOp_q      <= '0;
            dpArgA_q    <= '0;
            dpArgB_q    <= '0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspStatus_q <= '0;
            errCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastId_q    <= lastId_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            dpOp_q      <= dpOp_d;
            dpArgA_q    <= dpArgA_d;
            dpArgB_q    <= dpArgB_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspStatus_q <= rspStatus_d;
            errCnt_q    <= errCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastId_d    = lastId_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        dpOp_d      = dpOp_q;
        dpArgA_d    = dpArgA_q;
        dpArgB_d    = dpArgB_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspStatus_d = rspStatus_q;
        errCnt_d    = errCnt_q;
        unique case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d  = ISSUE;
                    dpOp_d   = selOp;
                    dpArgA_d = selArgA;
                    dpArgB_d = (selOp == OP_SM2U2) ? '0 : selArgB;
                    id_d     = grant;
                    lastId_d = grant;
                    cnt_d    = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + SW'(1);
                // Datapath result is trusted only once the operands have been held long enough.
                if (cnt_q == SW'(SETTLE - 1)) begin
                    state_d     = RESP;
                    rspResult_d = i_dp_status[0] ? '0 : i_dp_result;
                    rspStatus_d = i_dp_status;
                    rspId_d     = id_q;
                    if (i_dp_status[0] && (errCnt_q != {CNT_W{1'b1}})) begin
                        errCnt_d = errCnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        if ((state_q == IDLE) && anyValid) begin
            o_req0_ready = ~grant;
            o_req1_ready = grant;
        end
        o_rsp_valid = (state_q == RESP);
        o_busy      = (state_q != IDLE);
    end

    assign o_dp_op      = dpOp_q;
    assign o_dp_argA    = dpArgA_q;
    assign o_dp_argB    = dpArgB_q;
    assign o_rsp_id     = rspId_q;
    assign o_rsp_result = rspResult_q;
    assign o_rsp_status = rspStatus_q;
    assign o_err_cnt    = errCnt_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural sign-magnitude datapath
// (subtract / less-than / clear-bit / SM->U2) hanging off the o_dp_* outputs.
module tb_alu_rr_scheduler;

    localparam int M      = 4;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 2;

    logic             clk;
    logic             rstN;
    logic             req0Valid, req1Valid;
    logic             req0Ready, req1Ready;
    logic [1:0]       req0Op, req1Op;
    logic [M-1:0]     req0ArgA, req0ArgB, req1ArgA, req1ArgB;
    logic [1:0]       dpOp;
    logic [M-1:0]     dpArgA, dpArgB;
    logic [M-1:0]     dpResult;
    logic [3:0]       dpStatus;
    logic             rspValid, rspReady, rspId;
    logic [M-1:0]     rspResult;
    logic [3:0]       rspStatus;
    logic [CNT_W-1:0] errCnt;
    logic             busy;

    int nChecks = 0;
    int nFails  = 0;

    alu_rr_scheduler #(.M(M), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req0_valid (req0Valid),
        .o_req0_ready (req0Ready),
        .i_req0_op    (req0Op),
        .i_req0_argA  (req0ArgA),
        .i_req0_argB  (req0ArgB),
        .i_req1_valid (req1Valid),
        .o_req1_ready (req1Ready),
        .i_req1_op    (req1Op),
        .i_req1_argA  (req1ArgA),
        .i_req1_argB  (req1ArgB),
        .o_dp_op      (dpOp),
        .o_dp_argA    (dpArgA),
        .o_dp_argB    (dpArgB),
        .i_dp_result  (dpResult),
        .i_dp_status  (dpStatus),
        .o_rsp_valid  (rspValid),
        .i_rsp_ready  (rspReady),
        .o_rsp_id     (rspId),
        .o_rsp_result (rspResult),
        .o_rsp_status (rspStatus),
        .o_err_cnt    (errCnt),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int smVal(input logic [3:0] v);
        return v[3] ? -int'(v[2:0]) : int'(v[2:0]);
    endfunction

    logic [3:0] dpRes;
    logic       dpErr;
    int         diff;

    // Errors drive a junk result so the scheduler's zeroing of the captured result is visible.
    always_comb begin
        dpRes = 4'b0000;
        dpErr = 1'b0;
        diff  = 0;
        case (dpOp)
            2'b00: begin
                diff = smVal(dpArgA) - smVal(dpArgB);
                if (diff > 7 || diff < -7) dpErr = 1'b1;
                else if (diff < 0)         dpRes = {1'b1, 3'(-diff)};
                else                       dpRes = {1'b0, 3'(diff)};
            end
            2'b01:   dpRes = (smVal(dpArgA) < smVal(dpArgB)) ? 4'b0001 : 4'b0000;
            2'b10:   dpRes = dpArgA & ~(4'b0001 << dpArgB[1:0]);
            default: begin
                if (dpArgA == 4'b1000) dpErr = 1'b1;
                else                   dpRes = 4'(smVal(dpArgA));
            end
        endcase
        if (dpErr) begin
            dpResult = 4'b1011;
            dpStatus = 4'b0001;
        end else begin
            dpResult = dpRes;
            dpStatus = {&dpRes, ~^dpRes, dpRes[3], 1'b0};
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    // Presents one request from a single requester while the DUT is idle and lets it be accepted.
    task automatic applyStimulus(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            req0Valid = 1'b1; req0Op = op; req0ArgA = a; req0ArgB = b;
        end else begin
            req1Valid = 1'b1; req1Op = op; req1ArgA = a; req1ArgB = b;
        end
        #1;
        nChecks++;
        if ({req1Ready, req0Ready} !== (id ? 2'b10 : 2'b01)) begin
            nFails++;
            $display("[TB] FAIL accept_ready: ready1/0=%b expected %b", {req1Ready, req0Ready}, id ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
    endtask

    task automatic waitResponse();
        for (int i = 0; i < 10 && !rspValid; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic releaseResponse();
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        {req0Valid, req1Valid, rspReady} = '0;
        {req0Op, req0ArgA, req0ArgB, req1Op, req1ArgA, req1ArgB} = '0;
        #3;
        nChecks++;
        if ({req0Ready, req1Ready, dpOp, dpArgA, dpArgB, rspValid, rspId, rspResult, rspStatus, errCnt, busy} !== 25'd0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {req0Ready, req1Ready, dpOp, dpArgA, dpArgB, rspValid, rspId, rspResult, rspStatus, errCnt, busy});
        end
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    task automatic test_single_op();
        req0Valid = 1'b1; req0Op = 2'b00; req0ArgA = 4'b0011; req0ArgB = 4'b0101;
        #1;
        nChecks++;
        if (req0Ready !== 1'b1) begin
            nFails++; $display("[TB] FAIL single_ready0: got %b expected 1", req0Ready);
        end
        @(posedge clk);
        #1 req0Valid = 1'b0;
        nChecks++;
        if ({busy, rspValid, dpOp, dpArgA, dpArgB} !== {1'b1, 1'b0, 2'b00, 4'b0011, 4'b0101}) begin
            nFails++;
            $display("[TB] FAIL single_issue: busy/valid/op/A/B=%b expected 1_0_00_0011_0101", {busy, rspValid, dpOp, dpArgA, dpArgB});
        end
        @(posedge clk);
        #1;
        nChecks++;
        if ({rspValid, rspId, rspResult, rspStatus} !== {1'b1, 1'b0, 4'b1010, 4'b0110}) begin
            nFails++;
            $display("[TB] FAIL single_rsp: valid/id/result/status=%b expected 1_0_1010_0110", {rspValid, rspId, rspResult, rspStatus});
        end
        releaseResponse();
        nChecks++;
        if ({rspValid, busy} !== 2'b00) begin
            nFails++; $display("[TB] FAIL single_release: valid/busy=%b expected 00", {rspValid, busy});
        end
    endtask

    task automatic test_round_robin();
        logic       ids[4];
        logic [3:0] res[4];
        int         cyc[4];
        int         nRsp = 0;
        applyReset();
        req0Valid = 1'b1; req0Op = 2'b00; req0ArgA = 4'b0011; req0ArgB = 4'b0001;
        req1Valid = 1'b1; req1Op = 2'b01; req1ArgA = 4'b1001; req1ArgB = 4'b0010;
        rspReady  = 1'b1;
        for (int c = 0; c < 40 && nRsp < 4; c++) begin
            @(posedge clk);
            #1;
            if (rspValid) begin
                ids[nRsp] = rspId; res[nRsp] = rspResult; cyc[nRsp] = c;
                nRsp++;
            end
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        nChecks++;
        if (nRsp !== 4) begin
            nFails++; $display("[TB] FAIL rr_count: got %0d responses expected 4", nRsp);
        end
        for (int i = 0; i < nRsp; i++) begin
            nChecks++;
            if ({ids[i], res[i]} !== ((i % 2 == 0) ? 5'b0_0010 : 5'b1_0001)) begin
                nFails++;
                $display("[TB] FAIL rr_rsp%0d: id/result=%b expected %b", i, {ids[i], res[i]}, (i % 2 == 0) ? 5'b0_0010 : 5'b1_0001);
            end
            if (i > 0) begin
                nChecks++;
                if (cyc[i] - cyc[i-1] !== SETTLE + 2) begin
                    nFails++; $display("[TB] FAIL rr_interval%0d: got %0d cycles expected %0d", i, cyc[i] - cyc[i-1], SETTLE + 2);
                end
            end
        end
        @(posedge clk);
        #1 rspReady = 1'b0;
        nChecks++;
        if (busy !== 1'b0) begin
            nFails++; $display("[TB] FAIL rr_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_pressure();
        applyStimulus(1'b1, 2'b10, 4'b0111, 4'b0001);
        waitResponse();
        req0Valid = 1'b1; req0Op = 2'b00; req0ArgA = 4'b0001; req0ArgB = 4'b0001;
        req1Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if ({rspValid, rspId, rspResult, rspStatus} !== {1'b1, 1'b1, 4'b0101, 4'b0100}) begin
                nFails++;
                $display("[TB] FAIL bp_hold%0d: valid/id/result/status=%b expected 1_1_0101_0100", i, {rspValid, rspId, rspResult, rspStatus});
            end
            nChecks++;
            if ({req0Ready, req1Ready} !== 2'b00) begin
                nFails++; $display("[TB] FAIL bp_ready%0d: ready0/1=%b expected 00", i, {req0Ready, req1Ready});
            end
            @(posedge clk);
            #1;
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        releaseResponse();
        nChecks++;
        if ({rspValid, busy} !== 2'b00) begin
            nFails++; $display("[TB] FAIL bp_release: valid/busy=%b expected 00", {rspValid, busy});
        end
    endtask

    task automatic test_err_saturation();
        logic [1:0] expCnt[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'b00, 4'b0111, 4'b1111);
            waitResponse();
            nChecks++;
            if ({rspValid, rspResult, rspStatus, errCnt} !== {1'b1, 4'b0000, 4'b0001, expCnt[i]}) begin
                nFails++;
                $display("[TB] FAIL sat%0d: valid/result/status/errcnt=%b expected 1_0000_0001_%b", i, {rspValid, rspResult, rspStatus, errCnt}, expCnt[i]);
            end
            releaseResponse();
        end
    endtask

    task automatic test_sm2u2();
        applyStimulus(1'b0, 2'b11, 4'b1000, 4'b0110);
        nChecks++;
        if ({dpOp, dpArgA, dpArgB} !== {2'b11, 4'b1000, 4'b0000}) begin
            nFails++; $display("[TB] FAIL u2_argB: op/A/B=%b expected 11_1000_0000", {dpOp, dpArgA, dpArgB});
        end
        waitResponse();
        nChecks++;
        if ({rspValid, rspResult, rspStatus[0], errCnt} !== {1'b1, 4'b0000, 1'b1, 2'd3}) begin
            nFails++;
            $display("[TB] FAIL u2_negzero: valid/result/err/errcnt=%b expected 1_0000_1_11", {rspValid, rspResult, rspStatus[0], errCnt});
        end
        releaseResponse();
        applyStimulus(1'b1, 2'b11, 4'b1011, 4'b0101);
        nChecks++;
        if (dpArgB !== 4'b0000) begin
            nFails++; $display("[TB] FAIL u2_argB2: got %b expected 0000", dpArgB);
        end
        waitResponse();
        nChecks++;
        if ({rspValid, rspId, rspResult, rspStatus} !== {1'b1, 1'b1, 4'b1101, 4'b0010}) begin
            nFails++;
            $display("[TB] FAIL u2_neg3: valid/id/result/status=%b expected 1_1_1101_0010", {rspValid, rspId, rspResult, rspStatus});
        end
        releaseResponse();
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({busy, dpOp, dpArgA, dpArgB} !== {1'b0, 2'b11, 4'b1011, 4'b0000}) begin
            nFails++; $display("[TB] FAIL idle_hold: busy/op/A/B=%b expected 0_11_1011_0000", {busy, dpOp, dpArgA, dpArgB});
        end
    endtask

    task automatic test_reset_mid_op();
        bit sawRsp = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'b0011, 4'b0101);
        nChecks++;
        if (busy !== 1'b1) begin
            nFails++; $display("[TB] FAIL mid_busy: got %b expected 1", busy);
        end
        rstN = 1'b0;
        #1;
        nChecks++;
        if ({req0Ready, req1Ready, dpOp, dpArgA, dpArgB, rspValid, rspId, rspResult, rspStatus, errCnt, busy} !== 25'd0) begin
            nFails++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
                     {req0Ready, req1Ready, dpOp, dpArgA, dpArgB, rspValid, rspId, rspResult, rspStatus, errCnt, busy});
        end
        @(posedge clk);
        #1 rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 sawRsp |= rspValid;
        end
        nChecks++;
        if (sawRsp !== 1'b0) begin
            nFails++; $display("[TB] FAIL mid_no_rsp: response seen=%b expected 0", sawRsp);
        end
        req0Valid = 1'b1; req0Op = 2'b01; req0ArgA = 4'b0001; req0ArgB = 4'b0010;
        req1Valid = 1'b1; req1Op = 2'b00; req1ArgA = 4'b0011; req1ArgB = 4'b0001;
        #1;
        nChecks++;
        if ({req0Ready, req1Ready} !== 2'b10) begin
            nFails++; $display("[TB] FAIL mid_grant: ready0/1=%b expected 10", {req0Ready, req1Ready});
        end
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        waitResponse();
        nChecks++;
        if ({rspValid, rspId, rspResult, errCnt} !== {1'b1, 1'b0, 4'b0001, 2'd0}) begin
            nFails++;
            $display("[TB] FAIL mid_rsp: valid/id/result/errcnt=%b expected 1_0_0001_00", {rspValid, rspId, rspResult, errCnt});
        end
        releaseResponse();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_err_saturation();
        test_sm2u2();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
